// File: rtl/verifier_check_v_sr.sv
// Verifier side of the V-reduction sumcheck: checks prover tuples
// against a running folded copy of V and folds them with tau.
module verifier_check_v_sr #(
  parameter int nCopyBits = 4,
  parameter int F_NBITS   = 61
) (
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  logic restart,
  input  logic [F_NBITS-1:0] tau,
  input  logic [F_NBITS-1:0] m_tau_p1,
  input  logic [(1<<nCopyBits)-1:0][F_NBITS-1:0] in_vals,
  input  logic [3:0][F_NBITS-1:0] vals_in,
  input  logic vals_in_valid,
  output logic vals_in_ready,
  output logic err,
  output logic [nCopyBits-1:0] err_gate,
  output logic [$clog2(nCopyBits+1)-1:0] err_round,
  output logic [F_NBITS-1:0] final_out,
  output logic done,
  output logic ready,
  output logic ready_pulse
);

  localparam int N  = 1 << nCopyBits;
  localparam int KW = nCopyBits;
  localparam int RW = $clog2(nCopyBits+1);
  localparam int F  = F_NBITS;
  // Mersenne prime field: q = 2^F - 1
  localparam logic [F-1:0] Q = '1;

  typedef enum logic [1:0] {
    IDLE, ACCEPT, CHECK, FOLD
  } state_t;

  function automatic logic [F-1:0] fadd(
    input logic [F-1:0] a,
    input logic [F-1:0] b
  );
    logic [F:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[F-1:0];
  endfunction

  function automatic logic [F-1:0] fsub(
    input logic [F-1:0] a,
    input logic [F-1:0] b
  );
    return fadd(a, Q - b);
  endfunction

  // 2^F == 1 mod q, so high and low product halves simply add
  function automatic logic [F-1:0] fmul(
    input logic [F-1:0] a,
    input logic [F-1:0] b
  );
    logic [2*F-1:0] p;
    logic [F:0] s;
    logic [F:0] t;
    p = {{F{1'b0}}, a} * {{F{1'b0}}, b};
    s = {1'b0, p[F-1:0]} + {1'b0, p[2*F-1:F]};
    t = {1'b0, s[F-1:0]} + (F+1)'(s[F]);
    if (t >= {1'b0, Q}) t = t - {1'b0, Q};
    return t[F-1:0];
  endfunction

  state_t st;
  logic [N-1:0][F-1:0] vbuf;
  logic [3:0][F-1:0] lat;
  logic [F-1:0] tau_q;
  logic [F-1:0] mtau_q;
  logic [F-1:0] prod0;
  logic [F-1:0] prod1;
  logic [F-1:0] fold;
  logic [RW-1:0] r;
  logic [KW-1:0] k;
  logic [KW-1:0] i0;
  logic [KW-1:0] i1;
  logic [KW-1:0] g_last;
  logic bad;
  logic c_fail;

  always_comb begin
    i0 = k << 1;
    i1 = i0 | KW'(1);
    g_last = KW'((32'd1 << (nCopyBits - 1 - int'(r))) - 32'd1);
    fold = fadd(prod0, prod1);
    c_fail = (lat[0] != vbuf[i0])
           | (lat[1] != vbuf[i1])
           | (lat[2] != fsub(fadd(lat[0], lat[0]), lat[1]))
           | (lat[3] != fsub(fadd(lat[1], lat[1]), lat[0]));
  end

  // Fold writes in place: gate k only overwrites slots already consumed
  always_ff @(posedge clk) begin
    if (st == IDLE && en && restart) vbuf <= in_vals;
    else if (st == FOLD) vbuf[k] <= fold;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      st            <= IDLE;
      ready         <= 1'b1;
      ready_pulse   <= 1'b0;
      vals_in_ready <= 1'b0;
      err           <= 1'b0;
      err_gate      <= '0;
      err_round     <= '0;
      final_out     <= '0;
      done          <= 1'b0;
      r             <= '0;
      k             <= '0;
      tau_q         <= '0;
      mtau_q        <= '0;
      lat           <= '0;
      prod0         <= '0;
      prod1         <= '0;
      bad           <= 1'b0;
    end else begin
      ready_pulse <= 1'b0;
      unique case (st)
        IDLE: begin
          if (en && (restart || !done)) begin
            if (restart) begin
              r         <= '0;
              err       <= 1'b0;
              err_gate  <= '0;
              err_round <= '0;
              done      <= 1'b0;
            end
            tau_q         <= tau;
            mtau_q        <= m_tau_p1;
            k             <= '0;
            ready         <= 1'b0;
            vals_in_ready <= 1'b1;
            st            <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (vals_in_valid) begin
            lat           <= vals_in;
            vals_in_ready <= 1'b0;
            st            <= CHECK;
          end
        end
        CHECK: begin
          prod0 <= fmul(mtau_q, lat[0]);
          prod1 <= fmul(tau_q, lat[1]);
          bad   <= c_fail;
          st    <= FOLD;
        end
        FOLD: begin
          if (bad && !err) begin
            err       <= 1'b1;
            err_gate  <= k;
            err_round <= r;
          end
          if (k == g_last) begin
            r           <= r + RW'(1);
            ready       <= 1'b1;
            ready_pulse <= 1'b1;
            st          <= IDLE;
            if (r == RW'(nCopyBits - 1)) begin
              done      <= 1'b1;
              final_out <= fold;
            end
          end else begin
            k             <= k + KW'(1);
            vals_in_ready <= 1'b1;
            st            <= ACCEPT;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
